// File: rtl/result_writeback.sv
// Result write-back: buffers convolution output pixels, optionally applies ReLU and
// writes them to RAM B in channel-major order, flagging completion of the output volume.
module result_writeback #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  out_dim,
    input  logic [8:0]  out_depth,
    input  logic [15:0] write_base,
    input  logic        relu_en,
    input  logic        result_en,
    input  logic [7:0]  result_x,
    input  logic [7:0]  result_y,
    input  logic [8:0]  result_z,
    input  logic [17:0] result_data,
    output logic        result_block,
    output logic [15:0] ramb_write_addr,
    output logic [17:0] ramb_write_data,
    output logic        ramb_write_en,
    input  logic        ramb_stall,
    output logic        overflow,
    output logic        range_error,
    output logic        done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIGH_C  = CW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [8:0]  z;
        logic [17:0] data;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          in_range, room, push, pop;
    entry_t        head, in_entry;
    logic [15:0]   dim16;

    logic          a_valid_q;
    logic [15:0]   a_addr_q, a_addr_d;
    logic [17:0]   a_data_q, a_data_d;

    logic          wr_en_q;
    logic [15:0]   wr_addr_q;
    logic [17:0]   wr_data_q;

    logic [24:0]   wcount_q, wcount_d, total;
    logic          overflow_q, range_error_q, done_q;

    always_comb begin
        in_range = (result_x < out_dim) && (result_y < out_dim) && (result_z <= out_depth);
        pop      = (count_q != '0) && !ramb_stall;
        // A same-edge pop frees a slot, so a full FIFO still accepts the entry.
        room     = (count_q < DEPTH_C) || pop;
        push     = result_en && in_range && room;
        in_entry = '{x: result_x, y: result_y, z: result_z, data: result_data};
        head     = mem_q[rd_ptr_q];
        dim16    = {8'd0, out_dim};
        // 16-bit arithmetic gives the address modulo 65536 directly.
        a_addr_d = write_base + dim16 * dim16 * {7'd0, head.z}
                 + dim16 * {8'd0, head.y} + {8'd0, head.x};
        a_data_d = (relu_en && head.data[17]) ? '0 : head.data;
        wcount_d = wcount_q + 25'd1;
        total    = {17'd0, out_dim} * {17'd0, out_dim} * ({16'd0, out_depth} + 25'd1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            a_valid_q <= pop;
            if (pop) begin
                a_addr_q <= a_addr_d;
                a_data_q <= a_data_d;
            end
            wr_en_q <= a_valid_q;
            if (a_valid_q) begin
                wr_addr_q <= a_addr_q;
                wr_data_q <= a_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q      <= '0;
            overflow_q    <= 1'b0;
            range_error_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            if (result_en && !in_range) begin
                range_error_q <= 1'b1;
            end
            if (result_en && in_range && !room) begin
                overflow_q <= 1'b1;
            end
            if (wr_en_q) begin
                wcount_q <= wcount_d;
                if (wcount_d == total) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign result_block    = (count_q >= HIGH_C);
    assign ramb_write_en   = wr_en_q;
    assign ramb_write_addr = wr_addr_q;
    assign ramb_write_data = wr_data_q;
    assign overflow        = overflow_q;
    assign range_error     = range_error_q;
    assign done            = done_q;
endmodule

// File: tb/tb_result_writeback.sv
// Randomized and scenario-driven bench for result_writeback, checked every cycle
// against a queue-based reference model of the write-back behaviour.
module tb_result_writeback;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  out_dim = 8'd4;
    logic [8:0]  out_depth = 9'd1;
    logic [15:0] write_base = 16'h0100;
    logic        relu_en = 1'b0;
    logic        result_en = 1'b0;
    logic [7:0]  result_x = '0;
    logic [7:0]  result_y = '0;
    logic [8:0]  result_z = '0;
    logic [17:0] result_data = '0;
    logic        ramb_stall = 1'b0;
    logic        result_block;
    logic [15:0] ramb_write_addr;
    logic [17:0] ramb_write_data;
    logic        ramb_write_en;
    logic        overflow;
    logic        range_error;
    logic        done;

    result_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .out_dim(out_dim), .out_depth(out_depth),
        .write_base(write_base), .relu_en(relu_en), .result_en(result_en),
        .result_x(result_x), .result_y(result_y), .result_z(result_z),
        .result_data(result_data), .result_block(result_block),
        .ramb_write_addr(ramb_write_addr), .ramb_write_data(ramb_write_data),
        .ramb_write_en(ramb_write_en), .ramb_stall(ramb_stall),
        .overflow(overflow), .range_error(range_error), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted pixels in a queue, each pop emerging as a write two edges later.
    typedef struct {
        int          x;
        int          y;
        int          z;
        logic [17:0] d;
    } pix_t;

    pix_t        mq[$];
    bit          a_v, b_v;
    logic [15:0] a_addr, b_addr;
    logic [17:0] a_dat, b_dat;
    int          m_cnt;
    bit          m_done, m_ovf, m_rng;

    always @(posedge clk) begin : model
        int   total, dim, full;
        bit   popped;
        pix_t e;
        if (rst) begin
            mq.delete();
            a_v = 0; b_v = 0; m_cnt = 0;
            m_done = 0; m_ovf = 0; m_rng = 0;
        end else begin
            dim   = int'(out_dim);
            total = dim * dim * (int'(out_depth) + 1);
            if (b_v) begin
                m_cnt++;
                if (m_cnt == total) m_done = 1;
            end
            b_v = a_v; b_addr = a_addr; b_dat = a_dat;
            popped = (mq.size() > 0) && !ramb_stall;
            a_v = popped;
            if (popped) begin
                e      = mq.pop_front();
                full   = int'(write_base) + dim * dim * e.z + dim * e.y + e.x;
                a_addr = full[15:0];
                a_dat  = (relu_en && $signed(e.d) < 0) ? 18'd0 : e.d;
            end
            if (result_en) begin
                if (int'(result_x) >= dim || int'(result_y) >= dim || result_z > out_depth)
                    m_rng = 1;
                else if (mq.size() < DEPTH)
                    mq.push_back('{int'(result_x), int'(result_y), int'(result_z), result_data});
                else
                    m_ovf = 1;
            end
        end
    end

    int obs_writes = 0;

    always @(negedge clk) begin
        check_eq("wr_en", ramb_write_en, b_v);
        if (b_v) begin
            check_eq("wr_addr", ramb_write_addr, b_addr);
            check_eq("wr_data", ramb_write_data, b_dat);
        end
        check_eq("block", result_block, mq.size() >= DEPTH - 1);
        check_eq("overflow", overflow, m_ovf);
        check_eq("range_error", range_error, m_rng);
        check_eq("done", done, m_done);
        if (ramb_write_en) obs_writes++;
    end

    task automatic drive(input bit en, input int x, input int y, input int z, input logic [17:0] d);
        result_en   = en;
        result_x    = 8'(x);
        result_y    = 8'(y);
        result_z    = 9'(z);
        result_data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        result_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        result_en = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  base_w, dim, dep;
        bit  prev_blk, cur_blk, force_en;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_addr", ramb_write_addr, 16'h0);
        check_eq("rst_data", ramb_write_data, 18'h0);
        check_eq("rst_wr_en", ramb_write_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Full 4x4x2 volume in z,y,x order.
        base_w = obs_writes;
        for (int z = 0; z < 2; z++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++)
                    drive(1, x, y, z, 18'($urandom));
        idle(6);
        #1;
        check_eq("vol_writes", obs_writes - base_w, 32);
        check_eq("vol_done", done, 1'b1);

        relu_en = 1'b1;
        drive(1, 0, 0, 0, 18'h3FFFF);
        drive(1, 1, 0, 0, 18'h1FFFF);
        drive(1, 2, 0, 0, 18'h00000);
        idle(5);

        // Stall with a well-behaved producer: FIFO fills to depth without loss.
        relu_en = 1'b0;
        ramb_stall = 1'b1;
        prev_blk = 1'b0;
        base_w = obs_writes;
        for (int i = 0; i < 14; i++) begin
            #1;
            cur_blk = result_block;
            result_en   = !prev_blk;
            result_x    = 8'(i % 4);
            result_y    = 8'((i / 4) % 4);
            result_z    = 9'd0;
            result_data = 18'($urandom);
            prev_blk = cur_blk;
            @(negedge clk);
        end
        result_en = 1'b0;
        #1;
        check_eq("stall_block", result_block, 1'b1);
        check_eq("stall_no_ovf", overflow, 1'b0);
        ramb_stall = 1'b0;
        idle(12);
        #1;
        check_eq("stall_drain", obs_writes - base_w, 8);

        // Stall with a producer ignoring block: excess entries are dropped.
        ramb_stall = 1'b1;
        base_w = obs_writes;
        for (int i = 0; i < 10; i++) drive(1, i % 4, 1, 1, 18'($urandom));
        idle(1);
        #1;
        check_eq("force_ovf", overflow, 1'b1);
        ramb_stall = 1'b0;
        idle(12);
        #1;
        check_eq("force_drain", obs_writes - base_w, 8);

        // Out-of-range coordinates.
        do_reset(2);
        base_w = obs_writes;
        drive(1, 4, 0, 0, 18'h00123);
        drive(1, 0, 5, 0, 18'h00456);
        drive(1, 0, 0, 2, 18'h00789);
        idle(5);
        #1;
        check_eq("rng_flag", range_error, 1'b1);
        check_eq("rng_writes", obs_writes - base_w, 0);
        check_eq("rng_done", done, 1'b0);

        // Reset mid-run, then a complete 16-pixel volume.
        out_depth = 9'd0;
        do_reset(2);
        for (int i = 0; i < 5; i++) drive(1, i % 4, i / 4, 0, 18'($urandom));
        rst = 1'b1;
        result_en = 1'b0;
        @(negedge clk);
        #1;
        check_eq("no_wr_after_rst", ramb_write_en, 1'b0);
        check_eq("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        base_w = obs_writes;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                drive(1, x, y, 0, 18'($urandom));
        idle(6);
        #1;
        check_eq("rerun_writes", obs_writes - base_w, 16);
        check_eq("rerun_done", done, 1'b1);

        // Randomized rounds with random configuration, stalls and producer behaviour.
        for (int r = 0; r < 8; r++) begin
            rst = 1'b1;
            dim = $urandom_range(1, 5);
            dep = $urandom_range(0, 3);
            out_dim    = 8'(dim);
            out_depth  = 9'(dep);
            write_base = 16'($urandom);
            relu_en    = 1'($urandom);
            ramb_stall = 1'b0;
            do_reset(2);
            prev_blk = 1'b0;
            for (int c = 0; c < 150; c++) begin
                #1;
                cur_blk    = result_block;
                force_en   = ($urandom_range(0, 19) == 0);
                ramb_stall = ($urandom_range(0, 3) == 0);
                result_en  = ($urandom_range(0, 3) != 0) && (!prev_blk || force_en);
                result_x   = 8'($urandom_range(0, dim));
                result_y   = 8'($urandom_range(0, dim - 1));
                result_z   = 9'($urandom_range(0, dep + ((c % 17 == 0) ? 1 : 0)));
                result_data = 18'($urandom);
                prev_blk = cur_blk;
                @(negedge clk);
            end
            ramb_stall = 1'b0;
            idle(15);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
